// File: rtl/rr_arb8_if.sv
// rr_arb8_if: request/grant bundle between eight requesters and the rr_arb8
// round-robin arbiter.
//   master : requester side, drives req and observes the grant
//   slave  : arbiter side, samples req and drives the grant
interface rr_arb8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_vld
    );
endinterface

// File: rtl/rr_arb8.sv
// rr_arb8: 8-way round-robin arbiter with a registered one-hot grant.
// A grant is held while the holder keeps its request up. When the holder
// drops, the grant moves on the same edge to the next requester in cyclic
// order after the old holder.
//
// Optional build macro RR_ARB8_TIMEOUT_EN adds a hold-limit counter. With it,
// a holder is pre-empted after HOLD_MAX grant cycles, but only when another
// requester is waiting. Without the macro there is no counter, and grants
// last until they are released.
//
// state | meaning
// IDLE  | no grant outstanding; gnt, gnt_idx and gnt_vld are all zero
// GRANT | one requester owns the grant, whose index is held in gnt_idx
module rr_arb8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    rr_arb8_if.slave arb
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic [2:0] idx_nxt;

    logic [7:0] gnt_nxt;
    logic [2:0] gnt_idx_nxt;
    logic       gnt_vld_nxt;

    logic [2:0] holder_p1;
    logic       holder_req;
    logic [7:0] others;
    logic [3:0] idle_pick;
    logic [3:0] rel_pick;
    logic [3:0] tmo_pick;
    logic       tmo_move;

    if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_bad_hold_max
        $error("rr_arb8: HOLD_MAX must lie in 2..256");
    end

    // Cyclic priority pick: the first set bit of r at or after start, wrapping
    // from 7 to 0. The result is {found, index}. The loop runs from the
    // furthest offset down, so the closest hit is the last one written.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] pos;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            pos = start + 3'(k);
            if (r[pos]) begin
                res = {1'b1, pos};
            end
        end
        return res;
    endfunction

    assign holder_p1  = arb.gnt_idx + 3'd1;
    assign holder_req = arb.req[arb.gnt_idx];
    assign others     = arb.req & ~arb.gnt;
    assign idle_pick  = rr_pick(arb.req, ptr);
    // On release the holder's own bit is already clear, so the full request
    // vector can be scanned. It is scanned from just past the old holder.
    assign rel_pick   = rr_pick(arb.req, holder_p1);
    assign tmo_pick   = rr_pick(others, holder_p1);

`ifdef RR_ARB8_TIMEOUT_EN
    localparam int unsigned CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;

    assign tmo_move = (state == GRANT) && (hold_cnt == CNT_LIM) && (|others);

    // Hold counter: cleared on every new grant, incremented each grant cycle,
    // and saturated at the limit while nobody else is waiting.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if (state_nxt != GRANT || state == IDLE || idx_nxt != arb.gnt_idx) begin
            hold_cnt_nxt = '0;
        end else if (hold_cnt != CNT_LIM) begin
            hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
        end
    end
`else
    assign tmo_move = 1'b0;
`endif

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            arb.gnt     <= 8'h00;
            arb.gnt_idx <= 3'd0;
            arb.gnt_vld <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            arb.gnt     <= gnt_nxt;
            arb.gnt_idx <= gnt_idx_nxt;
            arb.gnt_vld <= gnt_vld_nxt;
        end
    end

    // Next state, next pointer and next holder index.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = arb.gnt_idx;
        case (state)
            IDLE: begin
                if (idle_pick[3]) begin
                    state_nxt = GRANT;
                    idx_nxt   = idle_pick[2:0];
                end else begin
                    idx_nxt   = 3'd0;
                end
            end
            GRANT: begin
                if (!holder_req) begin
                    ptr_nxt = holder_p1;
                    if (rel_pick[3]) begin
                        idx_nxt   = rel_pick[2:0];
                    end else begin
                        state_nxt = IDLE;
                        idx_nxt   = 3'd0;
                    end
                end else if (tmo_move) begin
                    ptr_nxt = holder_p1;
                    idx_nxt = tmo_pick[2:0];
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 3'd0;
            end
        endcase
    end

    // Grant outputs decoded from the next state, ready to be registered.
    always_comb begin
        gnt_vld_nxt = (state_nxt == GRANT);
        gnt_idx_nxt = gnt_vld_nxt ? idx_nxt : 3'd0;
        gnt_nxt     = gnt_vld_nxt ? (8'h01 << idx_nxt) : 8'h00;
    end

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed bench for rr_arb8. It applies a table of per-cycle
// vectors and then runs hand-written multi-cycle sequences: full-load
// rotation, reset during a grant and, when RR_ARB8_TIMEOUT_EN is defined,
// the hold limit.
module tb_rr_arb8;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    rr_arb8_if arb ();

    rr_arb8 #(.HOLD_MAX(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] eg, input logic [2:0] ei, input logic ev);
        tests++;
        if (arb.gnt !== eg || arb.gnt_idx !== ei || arb.gnt_vld !== ev) begin
            fails++;
            $display("FAIL %s: got gnt=%h idx=%0d vld=%b, expected gnt=%h idx=%0d vld=%b",
                     name, arb.gnt, arb.gnt_idx, arb.gnt_vld, eg, ei, ev);
        end
    endtask

    task automatic step(input logic [7:0] r);
        arb.req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs[25];

    initial begin
        logic [7:0] oh;
        int         e;

        tests = 0;
        fails = 0;

        vecs[0]  = '{8'h00, 8'h00, 3'd0, 1'b0};
        vecs[1]  = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[2]  = '{8'h00, 8'h00, 3'd0, 1'b0};
        vecs[3]  = '{8'h81, 8'h80, 3'd7, 1'b1};
        vecs[4]  = '{8'h81, 8'h80, 3'd7, 1'b1};
        vecs[5]  = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[6]  = '{8'h0F, 8'h01, 3'd0, 1'b1};
        vecs[7]  = '{8'h0E, 8'h02, 3'd1, 1'b1};
        vecs[8]  = '{8'h0F, 8'h02, 3'd1, 1'b1};
        vecs[9]  = '{8'h0D, 8'h04, 3'd2, 1'b1};
        vecs[10] = '{8'h09, 8'h08, 3'd3, 1'b1};
        vecs[11] = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[12] = '{8'h20, 8'h20, 3'd5, 1'b1};
        vecs[13] = '{8'h24, 8'h20, 3'd5, 1'b1};
        vecs[14] = '{8'h04, 8'h04, 3'd2, 1'b1};
        vecs[15] = '{8'h00, 8'h00, 3'd0, 1'b0};
        vecs[16] = '{8'h00, 8'h00, 3'd0, 1'b0};
        vecs[17] = '{8'h11, 8'h10, 3'd4, 1'b1};
        vecs[18] = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[19] = '{8'h11, 8'h01, 3'd0, 1'b1};
        vecs[20] = '{8'h12, 8'h02, 3'd1, 1'b1};
        vecs[21] = '{8'h14, 8'h04, 3'd2, 1'b1};
        vecs[22] = '{8'h16, 8'h04, 3'd2, 1'b1};
        vecs[23] = '{8'h12, 8'h10, 3'd4, 1'b1};
        vecs[24] = '{8'h00, 8'h00, 3'd0, 1'b0};

        rst_n   = 1'b0;
        arb.req = 8'h00;
        #3;
        check("reset_values", 8'h00, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h00);
        check("reset_release_idle", 8'h00, 3'd0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].req);
            check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].vld);
        end

        // full load: each holder keeps its bit for 3 cycles, then drops it once
        pulse_reset();
        step(8'hFF);
        for (int n = 0; n < 9; n++) begin
            e  = n % 8;
            oh = 8'h01 << e;
            check($sformatf("rot%0d_first", n), oh, 3'(e), 1'b1);
            if (n < 8) begin
                step(8'hFF);
                check($sformatf("rot%0d_hold", n), oh, 3'(e), 1'b1);
                step(8'hFF);
                check($sformatf("rot%0d_hold2", n), oh, 3'(e), 1'b1);
                step(8'hFF & ~oh);
            end
        end
        step(8'h00);
        check("rot_idle", 8'h00, 3'd0, 1'b0);

        // reset while index 3 holds the grant
        step(8'h08);
        check("pre_reset_grant3", 8'h08, 3'd3, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_grant", 8'h00, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", 8'h00, 3'd0, 1'b0);
        arb.req = 8'h88;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_scan_from0", 8'h08, 3'd3, 1'b1);
        step(8'h00);
        check("post_reset_idle", 8'h00, 3'd0, 1'b0);

`ifdef RR_ARB8_TIMEOUT_EN
        pulse_reset();
        step(8'h03);
        for (int blk = 0; blk < 3; blk++) begin
            e  = blk % 2;
            oh = 8'h01 << e;
            for (int c = 0; c < 16; c++) begin
                check($sformatf("tmo_alt_b%0d_c%0d", blk, c), oh, 3'(e), 1'b1);
                step(8'h03);
            end
        end
        pulse_reset();
        step(8'h10);
        for (int c = 0; c < 40; c++) begin
            check($sformatf("tmo_single_c%0d", c), 8'h10, 3'd4, 1'b1);
            step(8'h10);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
